// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop side, redirect flush and fill level.
interface if_id_queue_if #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_take;
  logic               if_ready;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic               id_take;
  logic               id_ready;
  logic               flush;
  logic [CNT_W-1:0]   occupancy;

  // Pipeline side (fetch, decode, redirect control)
  modport master (
    output if_valid, if_pc, if_instr, if_take, id_ready, flush,
    input  if_ready, id_valid, id_pc, id_instr, id_take, occupancy
  );

  // Queue side
  modport slave (
    input  if_valid, if_pc, if_instr, if_take, id_ready, flush,
    output if_ready, id_valid, id_pc, id_instr, id_take, occupancy
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: show-ahead FIFO between fetch and decode, cleared on redirect,
// presenting a NOP bubble to decode whenever no valid entry is available.
module if_id_queue #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  if_id_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [INSTR_W-1:0] INSTR_NOP = INSTR_W'(32'h0000_0013);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0]   take_mem;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic head_valid;
  logic push;
  logic pop;

  // Handshake qualifiers; only flush reaches the decode side combinationally
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CNT_W'(DEPTH));
    head_valid = ~empty & ~bus.flush;
    push       = bus.if_valid & ~full & ~bus.flush;
    pop        = head_valid & bus.id_ready;
  end

  assign bus.if_ready  = ~full;
  assign bus.id_valid  = head_valid;
  assign bus.id_pc     = head_valid ? pc_mem[rd_ptr_q]    : '0;
  assign bus.id_instr  = head_valid ? instr_mem[rd_ptr_q] : INSTR_NOP;
  assign bus.id_take   = head_valid & take_mem[rd_ptr_q];
  assign bus.occupancy = count_q;

  // Pointer/count next state; a redirect discards everything in flight
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is unreset; it is only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= bus.if_pc;
      instr_mem[wr_ptr_q] <= bus.if_instr;
      take_mem[wr_ptr_q]  <= bus.if_take;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic against a queue model.
module tb_if_id_queue;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        take;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ent_t        q[$];
  logic        exp_ready;
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_take;
  logic [1:0]  exp_occ;

  if_id_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and derive the expected outputs from the model queue
  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic take, input logic rdy, input logic fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = instr;
    bus.if_take  = take;
    bus.id_ready = rdy;
    bus.flush    = fl;
    exp_ready = (q.size() != DEPTH);
    exp_valid = (q.size() != 0) && !fl;
    exp_pc    = exp_valid ? q[0].pc    : 32'h0;
    exp_instr = exp_valid ? q[0].instr : NOP;
    exp_take  = exp_valid ? q[0].take  : 1'b0;
    exp_occ   = 2'(q.size());
  endtask

  // Apply the queue rules at the clock edge, then move to one step past it
  task automatic model_edge();
    bit do_pop;
    bit do_push;
    if (bus.flush) begin
      q.delete();
    end else begin
      do_pop  = (q.size() != 0) && bus.id_ready;
      do_push = bus.if_valid && (q.size() != DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: bus.if_pc, instr: bus.if_instr, take: bus.if_take});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[23:0], 8'h33};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 32'h0, 32'h0, 0, 0, 0);
    #12;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b want 1", bus.if_ready); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", bus.id_valid); end
    checks++; if (bus.id_instr !== NOP) begin errors++; $display("FAIL reset_id_instr got %h want %h", bus.id_instr, NOP); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    checks++; if (bus.id_pc !== 32'h0 || bus.id_take !== 1'b0) begin errors++; $display("FAIL reset_id_pc_take got %h/%b want 0/0", bus.id_pc, bus.id_take); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 32'(4 * k), mk_instr(32'(4 * k)), 0, 1, 0);
      #1;
      if (k > 0) begin
        checks++; if (bus.id_pc !== 32'(4 * (k - 1)) || bus.id_valid !== 1'b1) begin
          errors++; $display("FAIL stream_head[%0d] got pc=%h v=%b want pc=%h v=1", k, bus.id_pc, bus.id_valid, 4 * (k - 1));
        end
        checks++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", k, bus.occupancy); end
      end
      model_edge();
    end
    set_in(0, 32'h0, 32'h0, 0, 1, 0);
    #1;
    checks++; if (bus.id_pc !== 32'h8 || bus.id_instr !== mk_instr(32'h8)) begin
      errors++; $display("FAIL stream_last got pc=%h instr=%h want 8/%h", bus.id_pc, bus.id_instr, mk_instr(32'h8));
    end
    model_edge();
  endtask

  task automatic test_stall();
    set_in(1, 32'h10, mk_instr(32'h10), 0, 0, 0); #1; model_edge();
    set_in(1, 32'h14, mk_instr(32'h14), 1, 0, 0); #1;
    checks++; if (bus.id_pc !== 32'h10) begin errors++; $display("FAIL stall_head0 got %h want 10", bus.id_pc); end
    model_edge();
    set_in(1, 32'h18, mk_instr(32'h18), 0, 0, 0); #1;
    checks++; if (bus.occupancy !== 2'd2 || bus.if_ready !== 1'b0) begin
      errors++; $display("FAIL stall_full got occ=%0d rdy=%b want 2/0", bus.occupancy, bus.if_ready);
    end
    model_edge();
    set_in(1, 32'h18, mk_instr(32'h18), 0, 1, 0); #1;
    checks++; if (bus.occupancy !== 2'd2 || bus.id_pc !== 32'h10) begin
      errors++; $display("FAIL stall_hold got occ=%0d pc=%h want 2/10", bus.occupancy, bus.id_pc);
    end
    model_edge();
    set_in(1, 32'h18, mk_instr(32'h18), 0, 1, 0); #1;
    checks++; if (bus.id_pc !== 32'h14 || bus.id_take !== 1'b1) begin
      errors++; $display("FAIL stall_head1 got pc=%h take=%b want 14/1", bus.id_pc, bus.id_take);
    end
    model_edge();
    set_in(0, 32'h0, 32'h0, 0, 1, 0); #1;
    checks++; if (bus.id_pc !== 32'h18 || bus.occupancy !== 2'd1) begin
      errors++; $display("FAIL stall_head2 got pc=%h occ=%0d want 18/1", bus.id_pc, bus.occupancy);
    end
    model_edge();
  endtask

  task automatic test_flush();
    set_in(1, 32'h30, mk_instr(32'h30), 0, 0, 0); #1; model_edge();
    set_in(1, 32'h34, mk_instr(32'h34), 0, 0, 0); #1; model_edge();
    set_in(1, 32'h20, mk_instr(32'h20), 1, 1, 1); #1;
    checks++; if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP) begin
      errors++; $display("FAIL flush_cycle got v=%b instr=%h want 0/%h", bus.id_valid, bus.id_instr, NOP);
    end
    model_edge();
    set_in(1, 32'h40, mk_instr(32'h40), 1, 1, 0); #1;
    checks++; if (bus.occupancy !== 2'd0 || bus.id_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after got occ=%0d v=%b want 0/0", bus.occupancy, bus.id_valid);
    end
    model_edge();
    set_in(0, 32'h0, 32'h0, 0, 1, 0); #1;
    checks++; if (bus.id_pc !== 32'h40 || bus.id_valid !== 1'b1 || bus.id_take !== 1'b1) begin
      errors++; $display("FAIL flush_next_head got pc=%h v=%b take=%b want 40/1/1", bus.id_pc, bus.id_valid, bus.id_take);
    end
    model_edge();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(4 * k);
      set_in(k < 7, pc, mk_instr(pc), (k % 2) == 0, 1, 0);
      #1;
      if (k > 0) begin
        checks++; if (bus.id_pc !== 32'h100 + 32'(4 * (k - 1)) || bus.id_take !== (((k - 1) % 2) == 0)) begin
          errors++; $display("FAIL wrap[%0d] got pc=%h take=%b want pc=%h take=%b", k, bus.id_pc, bus.id_take,
                             32'h100 + 32'(4 * (k - 1)), ((k - 1) % 2) == 0);
        end
      end
      model_edge();
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 32'h50, mk_instr(32'h50), 0, 0, 0); #1; model_edge();
    set_in(1, 32'h54, mk_instr(32'h54), 0, 0, 0); #1; model_edge();
    set_in(0, 32'h0, 32'h0, 0, 0, 0);
    #1;
    checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL areset_pre got occ=%0d want 2", bus.occupancy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.occupancy !== 2'd0 || bus.if_ready !== 1'b1 || bus.id_valid !== 1'b0 || bus.id_instr !== NOP) begin
      errors++; $display("FAIL areset_mid got occ=%0d rdy=%b v=%b instr=%h want 0/1/0/%h",
                         bus.occupancy, bus.if_ready, bus.id_valid, bus.id_instr, NOP);
    end
    q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      set_in(($urandom % 4) != 0, pc, $urandom, 1'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
      #1;
      checks++; if (bus.if_ready !== exp_ready || bus.id_valid !== exp_valid || bus.occupancy !== exp_occ) begin
        errors++; $display("FAIL rand_ctrl[%0d] got rdy=%b v=%b occ=%0d want %b/%b/%0d", n,
                           bus.if_ready, bus.id_valid, bus.occupancy, exp_ready, exp_valid, exp_occ);
      end
      checks++; if (bus.id_pc !== exp_pc || bus.id_instr !== exp_instr || bus.id_take !== exp_take) begin
        errors++; $display("FAIL rand_head[%0d] got pc=%h instr=%h take=%b want %h/%h/%b", n,
                           bus.id_pc, bus.id_instr, bus.id_take, exp_pc, exp_instr, exp_take);
      end
      model_edge();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
